// File: rtl/note_lane_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : note_lane_renderer
//  Description : Scrolling buffer of note rows (one bit per lane). Each beat
//                rasterises the buffer to a VGA adapter, one pixel per clock,
//                then reports ready_for_song to the sequencer. Exposes the
//                bottom (hit-line) row to the scoring logic.
//                Optional macro DRAW_GRID_EN: paints the dx==0 / dy==0
//                pixels of every block white, giving a block grid.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_lane_renderer #(
    parameter int NUM_LANES = 4,
    parameter int NUM_ROWS  = 8,
    parameter int BLOCK_W   = 8,
    parameter int BLOCK_H   = 8,
    parameter int X_ORIGIN  = 0,
    parameter int Y_ORIGIN  = 0,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 game_enable,
    input  logic                 shift_song,
    input  logic                 beat_incremented,
    input  logic [NUM_LANES-1:0] note_in,
    output logic                 ready_for_song,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic [NUM_LANES-1:0] hit_row,
    output logic                 busy,
    output logic                 overrun
);

    localparam int ROW_W  = (NUM_ROWS  > 1) ? $clog2(NUM_ROWS)  : 1;
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int DX_W   = (BLOCK_W   > 1) ? $clog2(BLOCK_W)   : 1;
    localparam int DY_W   = (BLOCK_H   > 1) ? $clog2(BLOCK_H)   : 1;

    localparam logic [ROW_W-1:0]  C_ROW_LAST  = ROW_W'(NUM_ROWS - 1);
    localparam logic [LANE_W-1:0] C_LANE_LAST = LANE_W'(NUM_LANES - 1);
    localparam logic [DX_W-1:0]   C_DX_LAST   = DX_W'(BLOCK_W - 1);
    localparam logic [DY_W-1:0]   C_DY_LAST   = DY_W'(BLOCK_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_LANES-1:0]  rows_q [NUM_ROWS];
    logic [NUM_LANES-1:0]  rows_d [NUM_ROWS];
    logic [ROW_W-1:0]      row_q, row_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [DX_W-1:0]       dx_q, dx_d;
    logic [DY_W-1:0]       dy_q, dy_d;
    // Set once the final pixel has been issued; the draw then spends one
    // more cycle in S_DRAW while that last registered pixel is on the bus.
    logic                  done_q, done_d;
    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [2:0]            colour_q, colour_d;
    logic                  plot_q, plot_d;
    logic                  overrun_q, overrun_d;

    logic [X_W-1:0]        pix_x;
    logic [Y_W-1:0]        pix_y;
    logic [2:0]            pix_colour;
    logic                  note_bit;

    // Pixel address and colour for the current scan counters.
    always_comb begin
        pix_x    = X_W'(X_ORIGIN) + X_W'(lane_q) * X_W'(BLOCK_W) + X_W'(dx_q);
        pix_y    = Y_W'(Y_ORIGIN) + Y_W'(row_q) * Y_W'(BLOCK_H) + Y_W'(dy_q);
        note_bit = rows_q[row_q][lane_q];
        pix_colour = 3'b000;
        if (note_bit) begin
            case (lane_q)
                LANE_W'(0): pix_colour = 3'b100;
                LANE_W'(1): pix_colour = 3'b010;
                LANE_W'(2): pix_colour = 3'b001;
                default:    pix_colour = 3'b110;
            endcase
        end
`ifdef DRAW_GRID_EN
        if ((dx_q == '0) || (dy_q == '0)) begin
            pix_colour = 3'b111;
        end
`endif
    end

    // Next-state, buffer scroll, scan counter advance and pixel outputs.
    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        row_d     = row_q;
        lane_d    = lane_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        done_d    = done_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            S_IDLE: begin
                // Shift lands before a same-cycle draw start, so the draw
                // reads the post-shift buffer.
                if (shift_song) begin
                    for (int r = NUM_ROWS - 1; r >= 1; r--) begin
                        rows_d[r] = rows_q[r-1];
                    end
                    rows_d[0] = note_in;
                end
                if (beat_incremented) begin
                    state_d = S_DRAW;
                    row_d   = '0;
                    lane_d  = '0;
                    dx_d    = '0;
                    dy_d    = '0;
                    done_d  = 1'b0;
                end
            end
            S_DRAW: begin
                if (shift_song || beat_incremented) begin
                    overrun_d = 1'b1;
                end
                if (!done_q) begin
                    plot_d   = 1'b1;
                    x_d      = pix_x;
                    y_d      = pix_y;
                    colour_d = pix_colour;
                    if (dx_q != C_DX_LAST) begin
                        dx_d = dx_q + DX_W'(1);
                    end else begin
                        dx_d = '0;
                        if (dy_q != C_DY_LAST) begin
                            dy_d = dy_q + DY_W'(1);
                        end else begin
                            dy_d = '0;
                            if (lane_q != C_LANE_LAST) begin
                                lane_d = lane_q + LANE_W'(1);
                            end else begin
                                lane_d = '0;
                                if (row_q != C_ROW_LAST) begin
                                    row_d = row_q + ROW_W'(1);
                                end else begin
                                    row_d  = '0;
                                    done_d = 1'b1;
                                end
                            end
                        end
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (shift_song || beat_incremented) begin
                    overrun_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, buffer, counters and registered pixel outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            for (int r = 0; r < NUM_ROWS; r++) begin
                rows_q[r] <= '0;
            end
            row_q     <= '0;
            lane_q    <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            done_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= 3'b000;
            plot_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            row_q     <= row_d;
            lane_q    <= lane_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            done_q    <= done_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            overrun_q <= overrun_d;
        end
    end

    assign ready_for_song = game_enable & (state_q == S_IDLE) & ~reset;
    assign busy           = (state_q != S_IDLE);
    assign hit_row        = rows_q[NUM_ROWS-1];
    assign x              = x_q;
    assign y              = y_q;
    assign colour         = colour_q;
    assign plot           = plot_q;
    assign overrun        = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_note_lane_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_lane_renderer
//  Description : Self-checking bench for note_lane_renderer (default sizes).
//                Shift vectors from a table, whole-frame draws compared with
//                a pixel-index reference model, random buffer contents,
//                mid-draw strobes and reset mid-draw.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_lane_renderer;

    localparam int N = 8 * 4 * 8 * 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       game_enable;
    logic       shift_song;
    logic       beat_incremented;
    logic [3:0] note_in;
    logic       ready_for_song;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [3:0] hit_row;
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    logic [3:0] model_rows [8];

    typedef struct {
        logic [3:0] note;
        logic [3:0] exp_hit;
    } shift_vec_t;

    shift_vec_t vecs [9];

    note_lane_renderer dut (
        .clock            (clock),
        .reset            (reset),
        .game_enable      (game_enable),
        .shift_song       (shift_song),
        .beat_incremented (beat_incremented),
        .note_in          (note_in),
        .ready_for_song   (ready_for_song),
        .x                (x),
        .y                (y),
        .colour           (colour),
        .plot             (plot),
        .hit_row          (hit_row),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_shift(input logic [3:0] n);
        for (int r = 7; r >= 1; r--) model_rows[r] = model_rows[r-1];
        model_rows[0] = n;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 8; r++) model_rows[r] = 4'b0000;
    endtask

    // Expected pixel for scan index p (dx fastest, then dy, lane, row).
    function automatic logic [2:0] exp_colour(input int p);
        int dx   = p % 8;
        int dy   = (p / 8) % 8;
        int lane = (p / 64) % 4;
        int row  = p / 256;
        logic [2:0] lc [4];
        logic [3:0] r;
        logic [2:0] c;
        lc[0] = 3'b100; lc[1] = 3'b010; lc[2] = 3'b001; lc[3] = 3'b110;
        r = model_rows[row];
        c = r[lane] ? lc[lane] : 3'b000;
`ifdef DRAW_GRID_EN
        if (dx == 0 || dy == 0) c = 3'b111;
`endif
        return c;
    endfunction

    function automatic logic [7:0] exp_x(input int p);
        return 8'(((p / 64) % 4) * 8 + (p % 8));
    endfunction

    function automatic logic [6:0] exp_y(input int p);
        return 7'((p / 256) * 8 + (p / 8) % 8);
    endfunction

    // Drive one beat (optionally with a same-cycle shift), follow the whole
    // draw and check timing, ready_for_song and every pixel against the model.
    task automatic run_draw(input bit with_shift, input logic [3:0] n,
                            input bit mid_strobe, input string tag);
        int plots = 0, first_c = -1, last_c = -1, ready_c = -1;
        int ready_bad = 0, pix_bad = 0, bad_idx = -1;
        logic [7:0] bad_x = 0;
        logic [6:0] bad_y = 0;
        logic [2:0] bad_c = 0;
        logic [7:0] x0 = 0, x64 = 0;
        logic [6:0] y0 = 0, y64 = 0;
        logic [2:0] c0 = 0, c64 = 0;
        beat_incremented = 1'b1;
        if (with_shift) begin
            shift_song = 1'b1;
            note_in    = n;
        end
        for (int c = 1; c <= N + 10; c++) begin
            step();
            if (c == 1) begin
                beat_incremented = 1'b0;
                shift_song       = 1'b0;
                if (with_shift) model_shift(n);
            end
            if (mid_strobe) begin
                if (c == 500) game_enable = 1'b0;
                if (c == 600) game_enable = 1'b1;
                if (c == 1000) begin
                    shift_song = 1'b1; beat_incremented = 1'b1; note_in = 4'hF;
                end
                if (c == 1001) begin
                    shift_song = 1'b0; beat_incremented = 1'b0;
                end
            end
            if (plot === 1'b1) begin
                if (plots == 0)  begin x0 = x;  y0 = y;  c0 = colour;  end
                if (plots == 64) begin x64 = x; y64 = y; c64 = colour; end
                if (plots < N && (x !== exp_x(plots) || y !== exp_y(plots)
                                  || colour !== exp_colour(plots))) begin
                    if (pix_bad == 0) begin
                        bad_idx = plots; bad_x = x; bad_y = y; bad_c = colour;
                    end
                    pix_bad++;
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                plots++;
            end
            if (ready_for_song === 1'b1 && ready_c < 0) ready_c = c;
            if (c <= N + 2 && ready_for_song !== 1'b0) ready_bad++;
        end
        check({tag, "_plot_count"}, plots, N);
        check({tag, "_first_plot_cycle"}, first_c, 2);
        check({tag, "_last_plot_cycle"}, last_c, N + 1);
        check({tag, "_ready_rise_cycle"}, ready_c, N + 3);
        check({tag, "_ready_low_cycles"}, ready_bad, 0);
        check({tag, "_first_pixel_xyc"}, {x0, 1'b0, y0, 1'b0, c0},
              {exp_x(0), 1'b0, exp_y(0), 1'b0, exp_colour(0)});
        check({tag, "_lane1_pixel_xyc"}, {x64, 1'b0, y64, 1'b0, c64},
              {exp_x(64), 1'b0, exp_y(64), 1'b0, exp_colour(64)});
        total++;
        if (pix_bad != 0) begin
            bad++;
            $display("FAIL %s_pixels bad=%0d first_idx=%0d actual x=%0d y=%0d c=%b required x=%0d y=%0d c=%b",
                     tag, pix_bad, bad_idx, bad_x, bad_y, bad_c,
                     exp_x(bad_idx), exp_y(bad_idx), exp_colour(bad_idx));
        end
        check({tag, "_hit_row_after"}, hit_row, model_rows[7]);
    endtask

    initial begin
        int plots;
        logic [3:0] rn;
        vecs[0] = '{4'b0001, 4'b0000};
        vecs[1] = '{4'b0000, 4'b0000};
        vecs[2] = '{4'b0000, 4'b0000};
        vecs[3] = '{4'b0000, 4'b0000};
        vecs[4] = '{4'b0000, 4'b0000};
        vecs[5] = '{4'b0000, 4'b0000};
        vecs[6] = '{4'b0000, 4'b0000};
        vecs[7] = '{4'b0000, 4'b0001};
        vecs[8] = '{4'b0000, 4'b0000};

        reset = 1'b1; game_enable = 1'b1; shift_song = 1'b0;
        beat_incremented = 1'b0; note_in = 4'b0000;
        model_clear();
        step(); step(); step();
        check("ready_during_reset", ready_for_song, 1'b0);
        reset = 1'b0;
        step();
        check("reset_ready", ready_for_song, 1'b1);
        check("reset_plot", plot, 1'b0);
        check("reset_hit_row", hit_row, 4'b0000);
        check("reset_overrun", overrun, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_xyc", {x, y, colour}, 18'd0);
        game_enable = 1'b0; #1;
        check("ready_masked", ready_for_song, 1'b0);
        game_enable = 1'b1; #1;

        // Table-driven scroll vectors.
        for (int i = 0; i < 9; i++) begin
            shift_song = 1'b1; note_in = vecs[i].note;
            step();
            shift_song = 1'b0;
            model_shift(vecs[i].note);
            check($sformatf("shift_vec%0d_hit_row", i), hit_row, vecs[i].exp_hit);
        end

        // Single populated top row.
        shift_song = 1'b1; note_in = 4'b1010;
        step();
        shift_song = 1'b0;
        model_shift(4'b1010);
        run_draw(1'b0, 4'b0000, 1'b0, "draw1010");
        check("overrun_clean", overrun, 1'b0);

        // Strobes while busy are ignored but flagged.
        run_draw(1'b0, 4'b0000, 1'b1, "draw_midstrobe");
        check("overrun_set", overrun, 1'b1);
        run_draw(1'b0, 4'b0000, 1'b0, "draw_unchanged");

        // Same-cycle shift and beat in idle.
        run_draw(1'b1, 4'b1111, 1'b0, "draw_simul");

        // Random buffer contents.
        for (int i = 0; i < 20; i++) begin
            rn = 4'($urandom_range(0, 15));
            shift_song = 1'b1; note_in = rn;
            step();
            shift_song = 1'b0;
            model_shift(rn);
            check($sformatf("rand_shift%0d_hit_row", i), hit_row, model_rows[7]);
            if ($urandom_range(0, 1) == 1) step();
        end
        run_draw(1'b0, 4'b0000, 1'b0, "draw_random");
        check("overrun_sticky", overrun, 1'b1);

        // Reset at pixel 500 of a draw.
        beat_incremented = 1'b1;
        plots = 0;
        for (int c = 1; c <= N + 10 && plots < 500; c++) begin
            step();
            beat_incremented = 1'b0;
            if (plot === 1'b1) plots++;
        end
        check("rst_mid_reached_500", plots, 500);
        reset = 1'b1;
        step();
        check("rst_mid_plot", plot, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_hit_row", hit_row, 4'b0000);
        check("rst_mid_overrun", overrun, 1'b0);
        check("rst_mid_ready_in_reset", ready_for_song, 1'b0);
        reset = 1'b0;
        model_clear();
        plots = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (plot !== 1'b0) plots++;
        end
        check("rst_mid_no_plots", plots, 0);
        check("rst_mid_ready_after", ready_for_song, 1'b1);
        run_draw(1'b0, 4'b0000, 1'b0, "draw_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/note_lane_renderer.md
Name: note_lane_renderer

Overview:
Downstream consumer of the song-sequencer FSM's shiftSong/beatIncremented strobes. Holds a scrolling buffer of note rows, one bit per lane. On each beat it rasterises the buffer to the VGA adapter, one pixel per clock, then raises ready_for_song so the sequencer can advance. It also exposes the bottom (hit-line) row to the scoring logic.

Parameters:
NUM_LANES, 4, note lanes per row; legal 1..4
NUM_ROWS, 8, rows in scroll buffer; row 0 = top
BLOCK_W, 8, block width in pixels; power of 2
BLOCK_H, 8, block height in pixels; power of 2
X_ORIGIN, 0, x pixel of the top-left block
Y_ORIGIN, 0, y pixel of the top-left block
X_W, 8, x coordinate width
Y_W, 7, y coordinate width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
game_enable  input  1  gates ready_for_song
shift_song  input  1  one-cycle strobe: scroll the buffer down one row
beat_incremented  input  1  one-cycle strobe: start redraw
note_in  input  NUM_LANES  new top row, sampled on shift_song
ready_for_song  output  1  renderer idle and game enabled
x  output  X_W  pixel x
y  output  Y_W  pixel y
colour  output  3  pixel colour (RGB 1 bit each)
plot  output  1  pixel write enable
hit_row  output  NUM_LANES  buffer row NUM_ROWS-1
busy  output  1  high in S_DRAW or S_DONE
overrun  output  1  sticky: a strobe arrived while busy

Behaviour:
- Reset values: buffer, x, y, colour, plot, overrun = 0; state = S_IDLE; ready_for_song = 0 during the reset cycle.
- ready_for_song = game_enable & (state == S_IDLE); combinational from registered state.
- Shift on shift_song in S_IDLE: row[r] <= row[r-1] for r >= 1; row[0] <= note_in. Bottom row is discarded. hit_row updates on the next cycle.
- State S_IDLE: on beat_incremented, go to S_DRAW and clear row/lane/dy/dx counters.
- Same-cycle shift_song and beat_incremented in S_IDLE: both are accepted. The shift lands first, so the draw shows post-shift contents.
- State S_DRAW: emits one pixel per cycle.
  - Scan order: row 0..NUM_ROWS-1 (outer), then lane 0..NUM_LANES-1, then dy, then dx (innermost).
  - Registered outputs appear one cycle after the counter value: plot=1, x = X_ORIGIN + lane*BLOCK_W + dx, y = Y_ORIGIN + row*BLOCK_H + dy.
  - x and y are truncated to X_W/Y_W; wrap-around is accepted silently.
  - colour: note bit set gives lane colour (lane0 3'b100, lane1 3'b010, lane2 3'b001, lane3 3'b110); clear gives 3'b000.
- After the last pixel, go to S_DONE for one cycle with plot=0, then return to S_IDLE.
- Draw latency: beat_incremented at cycle T gives the first plot at T+2 and the last plot at T+1+N, where N = NUM_ROWS*NUM_LANES*BLOCK_W*BLOCK_H (2048 at defaults). ready_for_song rises at T+N+3.
- shift_song or beat_incremented while busy: ignored (buffer and draw unaffected); overrun <= 1. overrun is cleared only by reset.
- game_enable low does not stop a draw; it only masks ready_for_song.
- Reset mid-draw: immediate return to reset values; no further plot pulses.
- plot = 0 at all times outside S_DRAW.

Optional Feature:
DRAW_GRID_EN
- Defined: every pixel with dx == 0 or dy == 0 is drawn colour 3'b111 regardless of the note bit, giving a block grid. Timing is unchanged.
- Undefined: colour depends on the note bit only.

Test Plan:
- Reset, then game_enable=1 -> ready_for_song=1, plot=0, hit_row=0, overrun=0.
- shift_song with note_in=4'b0001, then 7 shifts with 0 -> hit_row=4'b0001 after the 8th shift; a 9th shift -> hit_row=0.
- Load row0=4'b1010, pulse beat_incremented at T:
  - exactly 2048 plot cycles T+2..T+2049; ready_for_song low throughout and high at T+2051;
  - first pixel x=0, y=0, colour 3'b000;
  - pixel (lane1, dx=0, dy=0) x=8, y=0, colour 3'b010.
- beat_incremented and shift_song mid-draw -> draw pixel count still 2048, buffer unchanged, overrun=1.
- Simultaneous shift_song(note_in=4'b1111) and beat_incremented in idle -> all row-0 pixels drawn in lane colours.
- Assert reset at pixel 500 of a draw -> plot=0 on the next cycle, buffer=0, state idle; with DRAW_GRID_EN, the first pixel of a redraw has colour 3'b111.
